// File: rtl/outport_sw_alloc_pkg.sv
// Shared types and helpers for the per-output-port switch allocator.
package outport_sw_alloc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_e;

    // Credit counters must be able to hold the value DEPTH itself.
    function automatic int cred_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/outport_sw_alloc_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or after ptr, wrapping mod PORTS.
module rr_pick #(
    parameter int PORTS = 5,
    parameter int PW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] elig,
    input  logic [PW-1:0]    ptr,
    output logic [PORTS-1:0] win
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (int'(ptr) + k >= PORTS) begin
                idx = PW'(int'(ptr) + k - PORTS);
            end else begin
                idx = PW'(int'(ptr) + k);
            end
            if (!found && elig[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/outport_sw_alloc.sv
// Per-output-port switch allocator: round-robin arbitration, wormhole lock, per-VC credit gating.
module outport_sw_alloc
    import outport_sw_alloc_pkg::*;
#(
    parameter int PORTS  = 5,
    parameter int VCHW   = 2,
    parameter int DEPTH  = 4,
    parameter int OUT_ID = 0
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [PORTS-1:0]   req,
    input  logic [PORTS*VCHW-1:0] vch,
    input  logic [PORTS-1:0]   tail,
    input  logic               cred_ret,
    input  logic [VCHW-1:0]    cred_vch,
    output logic [PORTS-1:0]   sel,
    output logic [PORTS-1:0]   grt,
    output logic [VCHW-1:0]    ovch,
    output logic               locked,
    output logic               cred_err
);

    localparam int NVCH = 2 ** VCHW;
    localparam int PW   = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CW   = cred_width(DEPTH);

    if (OUT_ID < 0 || OUT_ID >= PORTS) begin : g_bad_out_id
        $error("outport_sw_alloc: OUT_ID out of range");
    end

    alloc_state_e   state_q, state_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [VCHW-1:0] lvc_q, lvc_d;
    logic [CW-1:0]  cred_q [NVCH];
    logic [CW-1:0]  cred_d [NVCH];
    logic           cred_err_q, cred_err_d;

    logic [VCHW-1:0]  vch_arr [PORTS];
    logic [NVCH-1:0]  cred_avail;
    logic [PORTS-1:0] elig;
    logic [PORTS-1:0] pick;
    logic [PW-1:0]    win_idx;
    logic [PORTS-1:0] grant;
    logic [VCHW-1:0]  gvc;
    logic [PW-1:0]    gidx;
    logic             granted;

    always_comb begin
        cred_avail = '0;
        elig       = '0;
        for (int v = 0; v < NVCH; v++) begin
            cred_avail[v] = (cred_q[v] != '0);
        end
        for (int i = 0; i < PORTS; i++) begin
            vch_arr[i] = vch[i*VCHW +: VCHW];
            elig[i]    = req[i] && cred_avail[vch_arr[i]];
        end
    end

    rr_pick #(
        .PORTS (PORTS),
        .PW    (PW)
    ) u_rr_pick (
        .elig (elig),
        .ptr  (rr_ptr_q),
        .win  (pick)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (pick[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    // While locked only the owner on its locked VC may be granted; vch is ignored.
    always_comb begin
        grant = '0;
        gvc   = '0;
        gidx  = '0;
        if (state_q == IDLE) begin
            grant = pick;
            gvc   = vch_arr[win_idx];
            gidx  = win_idx;
        end else if (req[owner_q] && cred_avail[lvc_q]) begin
            grant[owner_q] = 1'b1;
            gvc            = lvc_q;
            gidx           = owner_q;
        end
        if (rst_) begin
            grant = '0;
        end
        granted = |grant;
        sel     = grant;
        grt     = grant;
        ovch    = granted ? gvc : '0;
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        lvc_d    = lvc_q;
        if (granted) begin
            if (tail[gidx]) begin
                state_d  = IDLE;
                rr_ptr_d = (gidx == PW'(PORTS - 1)) ? '0 : gidx + PW'(1);
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = gidx;
                lvc_d   = gvc;
            end
        end
    end

    // A send and a return on the same VC cancel out; a return at DEPTH is an upstream bug.
    always_comb begin
        cred_err_d = cred_err_q;
        for (int v = 0; v < NVCH; v++) begin
            cred_d[v] = cred_q[v];
            if (cred_ret && (cred_vch == VCHW'(v)) && !(granted && (gvc == VCHW'(v)))) begin
                if (cred_q[v] == CW'(DEPTH)) begin
                    cred_err_d = 1'b1;
                end else begin
                    cred_d[v] = cred_q[v] + CW'(1);
                end
            end else if (granted && (gvc == VCHW'(v)) && !(cred_ret && (cred_vch == VCHW'(v)))) begin
                cred_d[v] = cred_q[v] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lvc_q      <= '0;
            cred_err_q <= 1'b0;
            for (int v = 0; v < NVCH; v++) begin
                cred_q[v] <= CW'(DEPTH);
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lvc_q      <= lvc_d;
            cred_err_q <= cred_err_d;
            for (int v = 0; v < NVCH; v++) begin
                cred_q[v] <= cred_d[v];
            end
        end
    end

    assign locked   = (state_q == LOCKED);
    assign cred_err = cred_err_q;

endmodule

// File: tb/tb_outport_sw_alloc.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_outport_sw_alloc;

    localparam int PORTS = 5;
    localparam int VCHW  = 2;
    localparam int NVCH  = 4;
    localparam int DEPTH = 4;

    logic                  clk;
    logic                  rst_;
    logic [PORTS-1:0]      req;
    logic [PORTS*VCHW-1:0] vch;
    logic [PORTS-1:0]      tail;
    logic                  cred_ret;
    logic [VCHW-1:0]       cred_vch;
    logic [PORTS-1:0]      sel;
    logic [PORTS-1:0]      grt;
    logic [VCHW-1:0]       ovch;
    logic                  locked;
    logic                  cred_err;

    outport_sw_alloc #(
        .PORTS  (PORTS),
        .VCHW   (VCHW),
        .DEPTH  (DEPTH),
        .OUT_ID (0)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .req      (req),
        .vch      (vch),
        .tail     (tail),
        .cred_ret (cred_ret),
        .cred_vch (cred_vch),
        .sel      (sel),
        .grt      (grt),
        .ovch     (ovch),
        .locked   (locked),
        .cred_err (cred_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PORTS-1:0] sel;
        logic [VCHW-1:0]  ovch;
        logic             locked;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   stim_done = 1'b0;

    // Reference model: packet-level view of the allocator.
    int m_cred [NVCH];
    bit m_locked;
    int m_owner;
    int m_lvc;
    int m_ptr;
    bit m_err;

    task automatic model_reset();
        for (int v = 0; v < NVCH; v++) m_cred[v] = DEPTH;
        m_locked = 1'b0;
        m_owner  = 0;
        m_lvc    = 0;
        m_ptr    = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_step();
        exp_t e;
        int   g;
        int   gvc;
        g   = -1;
        gvc = 0;
        if (!rst_) begin
            if (m_locked) begin
                if (req[m_owner] && m_cred[m_lvc] > 0) begin
                    g   = m_owner;
                    gvc = m_lvc;
                end
            end else begin
                for (int k = 0; k < PORTS; k++) begin
                    int idx;
                    int vc;
                    idx = (m_ptr + k) % PORTS;
                    vc  = int'(vch[idx*VCHW +: VCHW]);
                    if (g < 0 && req[idx] && m_cred[vc] > 0) begin
                        g   = idx;
                        gvc = vc;
                    end
                end
            end
        end
        e.sel    = (g >= 0) ? PORTS'(1 << g) : '0;
        e.ovch   = (g >= 0) ? VCHW'(gvc) : '0;
        e.locked = m_locked;
        e.err    = m_err;
        exp_q.push_back(e);

        if (rst_) begin
            model_reset();
        end else begin
            if (g >= 0) m_cred[gvc] = m_cred[gvc] - 1;
            if (cred_ret) begin
                if (m_cred[int'(cred_vch)] == DEPTH) m_err = 1'b1;
                else m_cred[int'(cred_vch)] = m_cred[int'(cred_vch)] + 1;
            end
            if (g >= 0) begin
                if (tail[g]) begin
                    m_locked = 1'b0;
                    m_ptr    = (g + 1) % PORTS;
                end else if (!m_locked) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                    m_lvc    = gvc;
                end
            end
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic [PORTS-1:0] rq,
                                  input logic [PORTS*VCHW-1:0] vc, input logic [PORTS-1:0] tl,
                                  input logic cr, input logic [VCHW-1:0] cv);
        @(posedge clk);
        #1;
        rst_     = r;
        req      = rq;
        vch      = vc;
        tail     = tl;
        cred_ret = cr;
        cred_vch = cv;
        model_step();
    endtask

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("sel",      32'(sel),      32'(e.sel));
                check_output("grt",      32'(grt),      32'(e.sel));
                check_output("ovch",     32'(ovch),     32'(e.ovch));
                check_output("locked",   32'(locked),   32'(e.locked));
                check_output("cred_err", 32'(cred_err), 32'(e.err));
            end
        end
    end

    initial begin : stimulus
        logic [PORTS-1:0]      rq;
        logic [PORTS*VCHW-1:0] vc;
        logic [PORTS-1:0]      tl;
        logic                  cr;
        logic [VCHW-1:0]       cv;

        rst_ = 1'b1; req = '0; vch = '0; tail = '0; cred_ret = 1'b0; cred_vch = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state, then alternation of two single-flit requesters on VC0.
        apply_stimulus(1'b1, 5'b00000, '0, '0, 1'b0, 2'd0);
        repeat (4) apply_stimulus(1'b0, 5'b00110, '0, 5'b11111, 1'b0, 2'd0);

        // Input 3 locks on VC3 while input 0 also requests; tail on 4th flit.
        apply_stimulus(1'b0, 5'b01000, 10'b00_11_00_00_00, 5'b00000, 1'b0, 2'd0);
        repeat (2) apply_stimulus(1'b0, 5'b01001, 10'b00_11_00_00_00, 5'b00000, 1'b0, 2'd0);
        apply_stimulus(1'b0, 5'b01001, 10'b00_11_00_00_00, 5'b01000, 1'b0, 2'd0);
        apply_stimulus(1'b0, 5'b00000, '0, '0, 1'b1, 2'd3);
        repeat (3) apply_stimulus(1'b0, 5'b00000, '0, '0, 1'b1, 2'd3);

        // Credit exhaustion on VC1, then a single return allows one more flit.
        repeat (6) apply_stimulus(1'b0, 5'b00100, 10'b00_00_01_00_00, 5'b00000, 1'b0, 2'd0);
        apply_stimulus(1'b0, 5'b00000, '0, '0, 1'b1, 2'd1);
        repeat (2) apply_stimulus(1'b0, 5'b00100, 10'b00_00_01_00_00, 5'b00000, 1'b0, 2'd0);

        // Mid-packet reset, then a fresh requester.
        apply_stimulus(1'b1, 5'b00100, '0, '0, 1'b0, 2'd0);
        apply_stimulus(1'b0, 5'b10000, 10'b10_00_00_00_00, 5'b10000, 1'b0, 2'd0);

        // Simultaneous send and return on VC2, then a return at DEPTH on VC0.
        apply_stimulus(1'b0, 5'b00001, 10'b00_00_00_00_10, 5'b00001, 1'b1, 2'd2);
        apply_stimulus(1'b0, 5'b00000, '0, '0, 1'b1, 2'd0);
        repeat (2) apply_stimulus(1'b0, 5'b00000, '0, '0, 1'b0, 2'd0);

        // Owner stalls for two cycles while another input requests.
        apply_stimulus(1'b0, 5'b00001, '0, 5'b00000, 1'b0, 2'd0);
        repeat (2) apply_stimulus(1'b0, 5'b00010, '0, 5'b00010, 1'b0, 2'd0);
        apply_stimulus(1'b0, 5'b00011, '0, 5'b00011, 1'b0, 2'd0);
        apply_stimulus(1'b1, 5'b00000, '0, '0, 1'b0, 2'd0);

        for (int n = 0; n < 4000; n++) begin
            rq = PORTS'($urandom);
            vc = (PORTS*VCHW)'($urandom);
            tl = '0;
            for (int i = 0; i < PORTS; i++) tl[i] = ($urandom_range(0, 99) < 35);
            cv = VCHW'($urandom_range(0, NVCH - 1));
            if (m_cred[int'(cv)] < DEPTH) cr = ($urandom_range(0, 1) == 1);
            else cr = ($urandom_range(0, 39) == 0);
            apply_stimulus(($urandom_range(0, 299) == 0), rq, vc, tl, cr, cv);
        end

        repeat (3) @(posedge clk);
        stim_done = 1'b1;
    end

    initial begin : finisher
        wait (stim_done);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
